// File: rtl/rib_dma_if.sv
// RIB bus master/responder interface used by rib_dma.
// The master drives request, direction, address and write data; the
// responder (through the arbiter) returns a grant and read data that is
// valid in the same cycle as the grant.
interface rib_dma_if;
    logic        req_o;   // bus request
    logic        we_o;    // 1 = write, 0 = read
    logic [31:0] addr_o;  // byte address
    logic [31:0] data_o;  // write data
    logic [31:0] data_i;  // read data, valid with gnt_i
    logic        gnt_i;   // transaction completes when req_o && gnt_i

    modport master (
        output req_o,
        output we_o,
        output addr_o,
        output data_o,
        input  data_i,
        input  gnt_i
    );

    modport slave (
        input  req_o,
        input  we_o,
        input  addr_o,
        input  data_o,
        output data_i,
        output gnt_i
    );
endinterface

// File: rtl/rib_dma.sv
// rib_dma: word-aligned block mover on a RIB master port.
// A single start strobe loads source, destination and word count; the
// block then alternates one read and one write bus transaction per word
// and pulses done_o on completion. Misaligned addresses are rejected with
// an err_o pulse. abort_i cancels an active transfer without done_o.
//
// Optional feature: define RIB_DMA_FILL_EN to add the fill_i port. A start
// with fill_i = 1 skips the reads and writes FILL_WORD to cnt consecutive
// destination words, one word per cycle (source alignment is not checked).
// Without the macro every transfer is a copy and FILL_WORD has no effect.
module rib_dma #(
    parameter int          LEN_W     = 16,
    parameter logic [31:0] FILL_WORD = 32'h0
) (
    input  logic             clk,
    input  logic             rst,      // synchronous, active-low
    input  logic             start_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
`ifdef RIB_DMA_FILL_EN
    input  logic             fill_i,
`endif
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    rib_dma_if.master        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
    localparam logic [31:0]      WORD_INC = 32'd4;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;

    // Bus outputs are registered; data_q doubles as the one-word buffer
    // between the read and write halves of a copy.
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Fill request for the start being decoded. Tied low when the fill
    // feature is not built, so the fill paths below are pruned away.
    logic             fill_req;
`ifdef RIB_DMA_FILL_EN
    assign fill_req = fill_i;
`else
    assign fill_req = 1'b0;
`endif

    // Alignment check: the destination must always be word aligned; the
    // source only matters when it is actually read.
    logic start_misaligned;
    assign start_misaligned = (dst_i[1:0] != 2'b00) ||
                              (!fill_req && (src_i[1:0] != 2'b00));

    // Incremented pointers, used on every granted write.
    logic [31:0] src_inc, dst_inc;
    assign src_inc = src_q + WORD_INC;
    assign dst_inc = dst_q + WORD_INC;

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        // Empty transfer: report completion, no bus traffic.
                        state_d = ST_DONE;
                    end else if (start_misaligned) begin
                        // Rejected: nothing is latched, stay idle.
                        err_d = 1'b1;
                    end else begin
                        src_d  = src_i;
                        dst_d  = dst_i;
                        cnt_d  = len_i;
                        fill_d = fill_req;
                        req_d  = 1'b1;
                        if (fill_req) begin
                            state_d = ST_WR;
                            we_d    = 1'b1;
                            addr_d  = dst_i;
                            data_d  = FILL_WORD;
                        end else begin
                            state_d = ST_RD;
                            we_d    = 1'b0;
                            addr_d  = src_i;
                        end
                    end
                end
            end

            ST_RD: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else if (bus.gnt_i) begin
                    // Capture the read word and turn straight into the
                    // write; req_o stays high across the turnaround.
                    state_d = ST_WR;
                    data_d  = bus.data_i;
                    we_d    = 1'b1;
                    addr_d  = dst_q;
                end
            end

            ST_WR: begin
                if (abort_i) begin
                    // A write granted in this cycle still lands on the bus;
                    // the transfer state is simply abandoned.
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else if (bus.gnt_i) begin
                    src_d = src_inc;
                    dst_d = dst_inc;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                        req_d   = 1'b0;
                    end else if (fill_q) begin
                        // Fill keeps writing the same pattern, one word
                        // per cycle.
                        addr_d = dst_inc;
                    end else begin
                        state_d = ST_RD;
                        we_d    = 1'b0;
                        addr_d  = src_inc;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_o  = req_q;
    assign bus.we_o   = we_q;
    assign bus.addr_o = addr_q;
    assign bus.data_o = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_rib_dma.sv
// Directed testbench for rib_dma. A scoreboard queue holds the bus
// transactions each command should produce; a responder process grants
// requests, serves read data from an address-derived pattern and checks
// every requesting cycle against the head of the queue.
module tb_rib_dma;

    localparam int          LEN_W = 16;
    localparam logic [31:0] FILL  = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [31:0]      src_i;
    logic [31:0]      dst_i;
    logic [LEN_W-1:0] len_i;
    logic             fill_i;
    logic             abort_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic             gnt;

    int   errors = 0;
    int   checks = 0;
    txn_t exp_q[$];
    int   stall_rd = 0;
    int   rd_seen = 0;
    int   wr_seen = 0;

    always #5 clk = ~clk;

    rib_dma_if bus ();

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    assign bus.gnt_i  = gnt;
    assign bus.data_i = rd_pat(bus.addr_o);

    rib_dma #(
        .LEN_W     (LEN_W),
        .FILL_WORD (FILL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .src_i   (src_i),
        .dst_i   (dst_i),
        .len_i   (len_i),
`ifdef RIB_DMA_FILL_EN
        .fill_i  (fill_i),
`endif
        .abort_i (abort_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        for (int i = 0; i < len; i++) begin
            txn_t t;
            t.we   = 1'b0;
            t.addr = src + (32'(i) << 2);
            t.data = 32'h0;
            exp_q.push_back(t);
            t.we   = 1'b1;
            t.addr = dst + (32'(i) << 2);
            t.data = rd_pat(src + (32'(i) << 2));
            exp_q.push_back(t);
        end
    endtask

    task automatic push_fill(input logic [31:0] dst, input int len);
        for (int i = 0; i < len; i++) begin
            txn_t t;
            t.we   = 1'b1;
            t.addr = dst + (32'(i) << 2);
            t.data = FILL;
            exp_q.push_back(t);
        end
    endtask

    // Called just after a falling edge; returns just after the falling
    // edge that follows the rising edge on which start was sampled.
    task automatic do_start(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input logic fill);
        start_i = 1'b1;
        src_i   = src;
        dst_i   = dst;
        len_i   = LEN_W'(len);
        fill_i  = fill;
        @(negedge clk);
        start_i = 1'b0;
        fill_i  = 1'b0;
    endtask

    task automatic wait_done(input int exp_cycles, input string tag);
        int c = 0;
        while (!done_o && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_cycles"}, 32'(c), 32'(exp_cycles));
        chk({tag, "_done"}, {31'b0, done_o}, 32'd1);
        chk({tag, "_req_in_done"}, {31'b0, bus.req_o}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, done_o}, 32'd0);
        chk({tag, "_busy_idle"}, {31'b0, busy_o}, 32'd0);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req"},  {31'b0, bus.req_o}, 32'd0);
        chk({tag, "_we"},   {31'b0, bus.we_o},  32'd0);
        chk({tag, "_addr"}, bus.addr_o,         32'd0);
        chk({tag, "_data"}, bus.data_o,         32'd0);
        chk({tag, "_busy"}, {31'b0, busy_o},    32'd0);
        chk({tag, "_done"}, {31'b0, done_o},    32'd0);
        chk({tag, "_err"},  {31'b0, err_o},     32'd0);
    endtask

    // Responder and bus monitor: decides the grant for the coming edge,
    // then checks the requesting cycle against the scoreboard head.
    initial begin
        int wait_cnt = 0;
        gnt = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_rd != 0 && bus.req_o && !bus.we_o && wait_cnt < 3) begin
                gnt = 1'b0;
                wait_cnt++;
            end else begin
                gnt = 1'b1;
                wait_cnt = 0;
            end
            if (rst && bus.req_o) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_txn: observed addr %h we %0d expected no request",
                           bus.addr_o, bus.we_o);
                end
                if (exp_q.size() != 0) begin
                    chk("bus_we", {31'b0, bus.we_o}, {31'b0, exp_q[0].we});
                    chk("bus_addr", bus.addr_o, exp_q[0].addr);
                    if (gnt) begin
                        if (exp_q[0].we) begin
                            chk("bus_wdata", bus.data_o, exp_q[0].data);
                            wr_seen++;
                        end else begin
                            rd_seen++;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic        found;
        logic [31:0] ab_dst;

        rst     = 1'b0;
        start_i = 1'b0;
        src_i   = '0;
        dst_i   = '0;
        len_i   = '0;
        fill_i  = 1'b0;
        abort_i = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        $display("step: reset released");

        // Copy 4 words, grant always high.
        push_copy(32'h1000_0000, 32'h1000_0100, 4);
        do_start(32'h1000_0000, 32'h1000_0100, 4, 1'b0);
        chk("copy4_first_req", {31'b0, bus.req_o}, 32'd1);
        chk("copy4_busy", {31'b0, busy_o}, 32'd1);
        wait_done(8, "copy4");
        $display("step: copy 4 words, continuous grant");

        // Same copy with three stall cycles in every read.
        stall_rd = 1;
        push_copy(32'h1000_0000, 32'h1000_0100, 4);
        do_start(32'h1000_0000, 32'h1000_0100, 4, 1'b0);
        wait_done(20, "stall");
        stall_rd = 0;
        $display("step: copy 4 words, stalled reads");

        // Misaligned source and destination are rejected.
        do_start(32'h1000_0002, 32'h1000_0100, 4, 1'b0);
        chk("mis_src_err", {31'b0, err_o}, 32'd1);
        chk("mis_src_req", {31'b0, bus.req_o}, 32'd0);
        chk("mis_src_busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk);
        chk("mis_src_err_pulse", {31'b0, err_o}, 32'd0);
        chk("mis_src_req_after", {31'b0, bus.req_o}, 32'd0);
        do_start(32'h1000_0000, 32'h1000_0101, 2, 1'b0);
        chk("mis_dst_err", {31'b0, err_o}, 32'd1);
        @(negedge clk);
        $display("step: misaligned starts rejected");

        // Zero-length transfer completes without bus traffic.
        do_start(32'h1000_0000, 32'h1000_0100, 0, 1'b0);
        wait_done(0, "len0");
        $display("step: zero-length transfer");

        // Abort during the write of word 2 of 5.
        rd_seen = 0;
        wr_seen = 0;
        ab_dst  = 32'h1000_0200;
        push_copy(32'h1000_0040, ab_dst, 2);
        do_start(32'h1000_0040, ab_dst, 5, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.req_o && bus.we_o && bus.addr_o == ab_dst + 32'd4)
                found = 1'b1;
            else
                @(negedge clk);
        end
        chk("abort_reached", {31'b0, found}, 32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_req_low", {31'b0, bus.req_o}, 32'd0);
        chk("abort_no_done", {31'b0, done_o}, 32'd0);
        chk("abort_busy_low", {31'b0, busy_o}, 32'd0);
        @(negedge clk);
        chk("abort_no_done_late", {31'b0, done_o}, 32'd0);
        chk("abort_writes", 32'(wr_seen), 32'd2);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("step: abort in write of word 2");

        // A new start after the abort.
        push_copy(32'h3000_0000, 32'h3000_0800, 2);
        do_start(32'h3000_0000, 32'h3000_0800, 2, 1'b0);
        wait_done(4, "post_abort");
        $display("step: copy after abort");

        // Destination wraps past the top of the address space.
        push_copy(32'h2000_0000, 32'hFFFF_FFF8, 3);
        do_start(32'h2000_0000, 32'hFFFF_FFF8, 3, 1'b0);
        wait_done(6, "wrap");
        $display("step: destination address wrap");

`ifdef RIB_DMA_FILL_EN
        // Fill mode: writes only, one per cycle, source ignored.
        rd_seen = 0;
        wr_seen = 0;
        push_fill(32'h4000_0000, 3);
        do_start(32'h0000_0003, 32'h4000_0000, 3, 1'b1);
        chk("fill_first_we", {31'b0, bus.we_o}, 32'd1);
        wait_done(3, "fill");
        chk("fill_reads", 32'(rd_seen), 32'd0);
        chk("fill_writes", 32'(wr_seen), 32'd3);
        $display("step: fill 3 words");
`endif

        // Reset in the middle of a transfer.
        push_copy(32'h5000_0000, 32'h5000_0400, 5);
        do_start(32'h5000_0000, 32'h5000_0400, 5, 1'b0);
        repeat (2) @(negedge clk);
        chk("midrst_active", {31'b0, bus.req_o}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midrst");
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        $display("step: reset mid-transfer");

        // Recovery after reset.
        push_copy(32'h6000_0010, 32'h6000_0020, 1);
        do_start(32'h6000_0010, 32'h6000_0020, 1, 1'b0);
        wait_done(2, "post_rst");
        $display("step: copy after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rib_dma.md
# rib_dma

Bus-initiator block that moves word-aligned blocks of memory across the RIB bus, acting as the master end of the same request/grant interface the on-chip RAM and peripherals answer as responders. It is configured by a single start pulse carrying source, destination and length, then alternates one read and one write bus transaction per word. It reports completion or error to its controller, typically a CSR/peripheral wrapper or the debug module. It sits on a RIB master port behind the bus arbiter.

## Interface
- LEN_W, default 16: width of the word-count field; maximum transfer is 2^LEN_W - 1 words.
- FILL_WORD, default 32'h0: fill pattern, used only when RIB_DMA_FILL_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low; block is in reset while rst == 0 at the clock edge.
- start_i  in  1  one-cycle command strobe; sampled only in IDLE.
- src_i  in  32  source byte address; sampled with start_i.
- dst_i  in  32  destination byte address; sampled with start_i.
- len_i  in  LEN_W  number of 32-bit words to move; sampled with start_i.
- fill_i  in  1  fill-mode select; present only when RIB_DMA_FILL_EN is defined.
- abort_i  in  1  cancels an active transfer.
- busy_o  out  1  high from the cycle after an accepted start until the cycle the block returns to IDLE.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  one-cycle pulse when a start is rejected.
- req_o  out  1  bus request.
- we_o  out  1  write enable; 1 = write, 0 = read.
- addr_o  out  32  bus byte address.
- data_o  out  32  write data.
- data_i  in  32  read data from the responder; valid in the same cycle as gnt_i.
- gnt_i  in  1  arbiter grant; a transaction completes in any cycle where req_o and gnt_i are both 1.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- **IDLE**
  - On start_i with len_i == 0: go to DONE; no bus traffic.
  - On start_i with src_i[1:0] != 0 or dst_i[1:0] != 0: pulse err_o, stay in IDLE, latch nothing.
  - Otherwise: latch src, dst and cnt = len_i, then go to RD.
- **RD**
  - Drives req_o = 1, we_o = 0, addr_o = src.
  - On gnt_i: capture data_i into the word buffer and go to WR.
  - Without gnt_i: hold all outputs stable.
- **WR**
  - Drives req_o = 1, we_o = 1, addr_o = dst, data_o = buffer.
  - On gnt_i:
    - src += 4 and dst += 4, both modulo 2^32 (wrap from 32'hFFFF_FFFC to 0 without error).
    - cnt -= 1.
    - If the old cnt == 1, go to DONE; else go to RD.
- **DONE**: done_o = 1 for exactly one cycle, then IDLE.
- **Abort**: abort_i in RD or WR returns the FSM to IDLE at the next edge, with req_o = 0 from that edge.
  - No done_o pulse.
  - A completed write in the abort cycle (gnt_i high) still counts as done on the bus.
- **Other inputs**: start_i outside IDLE is ignored; abort_i in IDLE or DONE is ignored.
- **Reset mid-transfer**: outputs return to reset values at the next edge; the transfer is lost.

## Timing
- Reset values: req_o 0, we_o 0, addr_o 0, data_o 0, busy_o 0, done_o 0, err_o 0; FSM in IDLE.
- Command to first req_o: 1 cycle (start sampled at edge N, req_o high after edge N).
- With gnt_i continuously high:
  - Each word takes 2 cycles (1 read + 1 write).
  - An N-word transfer takes 2N cycles of req_o.
  - done_o follows in the cycle after the last write grant.
- req_o is never dropped between RD and WR of the same word.
- addr_o, we_o and data_o are registered outputs. They change only on edges where a grant or state change occurs.
- err_o is asserted in the cycle after the rejected start.

## Configuration
- **RIB_DMA_FILL_EN defined**:
  - fill_i port exists.
  - A start with fill_i = 1 skips RD entirely: IDLE → WR, writing FILL_WORD to dst for cnt words, 1 cycle per word.
  - src_i is not checked for alignment in fill mode.
- **Not defined**: fill_i is absent and every transfer is a copy.

## Test plan
- Copy 4 words, src 0x1000_0000, dst 0x1000_0100, gnt_i tied 1 → 8 bus cycles alternating read/write at 0x..00/0x..100 through 0x..0C/0x..10C; destination matches source; done_o 1 cycle after the last write.
- Same copy with gnt_i low for 3 cycles in each RD → addr_o, we_o and req_o stable while waiting; data correct; no extra transactions.
- start_i with src_i = 0x1000_0002 → err_o pulses once, req_o stays 0, busy_o stays 0; len_i = 0 → done_o pulse, no req_o.
- abort_i during WR of word 2 of 5 → req_o low next cycle, no done_o, exactly 2 writes seen; a new start then works normally.
- dst = 0xFFFF_FFF8, len 3 → writes at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- RIB_DMA_FILL_EN defined, FILL_WORD = 32'hDEAD_BEEF, fill_i = 1, len 3 → 3 consecutive write cycles, no reads; rst driven low mid-transfer → all outputs 0 at the next edge.
